// File: rtl/rgb_channel_router.sv
// Registered RGB channel router: any input channel to any output channel, with
// per-channel inversion and a forced-zero source. Config commits on a VSync rising edge.
module rgb_channel_router #(
  parameter int CH_W   = 8,
  parameter int NUM_CH = 3,
  parameter int SEL_W  = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH*CH_W-1:0]   vid_pData_in,
  input  logic                     vid_pVDE_in,
  input  logic                     vid_pHSync_in,
  input  logic                     vid_pVSync_in,
  input  logic [NUM_CH*SEL_W-1:0]  route_sel,
  input  logic [NUM_CH-1:0]        invert,
  input  logic                     cfg_update,
  output logic [NUM_CH*CH_W-1:0]   vid_pData_out,
  output logic                     vid_pVDE_out,
  output logic                     vid_pHSync_out,
  output logic                     vid_pVSync_out,
  output logic                     cfg_pending
);

  localparam int DW = NUM_CH * CH_W;
  localparam int SW = NUM_CH * SEL_W;

  function automatic logic [SW-1:0] identity_sel();
    logic [SW-1:0] r;
    r = '0;
    for (int i = 0; i < NUM_CH; i++) r[i*SEL_W +: SEL_W] = SEL_W'(i);
    return r;
  endfunction

  localparam logic [SW-1:0] ID_SEL = identity_sel();

  // Select values >= NUM_CH match no channel and therefore yield zero.
  function automatic logic [CH_W-1:0] route_one(input logic [DW-1:0] d,
                                                input logic [SEL_W-1:0] sel);
    logic [CH_W-1:0] r;
    r = '0;
    for (int j = 0; j < NUM_CH; j++)
      if (sel == SEL_W'(j)) r = d[j*CH_W +: CH_W];
    return r;
  endfunction

  logic [DW-1:0]     data_s1;
  logic              vde_s1;
  logic              hs_s1;
  logic              vs_s1;
  logic [SW-1:0]     sel_pend;
  logic [NUM_CH-1:0] inv_pend;
  logic [SW-1:0]     sel_act;
  logic [NUM_CH-1:0] inv_act;
  logic              vs_edge;
  logic [DW-1:0]     routed;

  // vs_s1 doubles as the previous-cycle vsync sample used for edge detection.
  assign vs_edge = vid_pVSync_in & ~vs_s1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_s1 <= '0;
      vde_s1  <= 1'b0;
      hs_s1   <= 1'b0;
      vs_s1   <= 1'b0;
    end else begin
      data_s1 <= vid_pData_in;
      vde_s1  <= vid_pVDE_in;
      hs_s1   <= vid_pHSync_in;
      vs_s1   <= vid_pVSync_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_pend <= ID_SEL;
      inv_pend <= '0;
    end else if (cfg_update) begin
      sel_pend <= route_sel;
      inv_pend <= invert;
    end
  end

  // A strobe on the edge cycle bypasses the shadow so the newest write wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_act     <= ID_SEL;
      inv_act     <= '0;
      cfg_pending <= 1'b0;
    end else if (vs_edge) begin
      if (cfg_update) begin
        sel_act <= route_sel;
        inv_act <= invert;
      end else if (cfg_pending) begin
        sel_act <= sel_pend;
        inv_act <= inv_pend;
      end
      cfg_pending <= 1'b0;
    end else if (cfg_update) begin
      cfg_pending <= 1'b1;
    end
  end

  always_comb begin
    routed = '0;
    if (vde_s1) begin
      for (int i = 0; i < NUM_CH; i++)
        routed[i*CH_W +: CH_W] = route_one(data_s1, sel_act[i*SEL_W +: SEL_W])
                                 ^ {CH_W{inv_act[i]}};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vid_pData_out  <= '0;
      vid_pVDE_out   <= 1'b0;
      vid_pHSync_out <= 1'b0;
      vid_pVSync_out <= 1'b0;
    end else begin
      vid_pData_out  <= routed;
      vid_pVDE_out   <= vde_s1;
      vid_pHSync_out <= hs_s1;
      vid_pVSync_out <= vs_s1;
    end
  end

endmodule

// File: tb/tb_rgb_channel_router.sv
// Directed bench for rgb_channel_router: routing, inversion, blanking and
// vsync-synchronised config commit, with hand-computed expected pixels.
module tb_rgb_channel_router;

  logic        clk;
  logic        rst_n;
  logic [23:0] vid_pData_in;
  logic        vid_pVDE_in;
  logic        vid_pHSync_in;
  logic        vid_pVSync_in;
  logic [5:0]  route_sel;
  logic [2:0]  invert;
  logic        cfg_update;
  logic [23:0] vid_pData_out;
  logic        vid_pVDE_out;
  logic        vid_pHSync_out;
  logic        vid_pVSync_out;
  logic        cfg_pending;

  int n_cmp = 0;
  int n_err = 0;

  rgb_channel_router #(.CH_W(8), .NUM_CH(3), .SEL_W(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .vid_pData_in(vid_pData_in), .vid_pVDE_in(vid_pVDE_in),
    .vid_pHSync_in(vid_pHSync_in), .vid_pVSync_in(vid_pVSync_in),
    .route_sel(route_sel), .invert(invert), .cfg_update(cfg_update),
    .vid_pData_out(vid_pData_out), .vid_pVDE_out(vid_pVDE_out),
    .vid_pHSync_out(vid_pHSync_out), .vid_pVSync_out(vid_pVSync_out),
    .cfg_pending(cfg_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe_cfg(input logic [5:0] sel, input logic [2:0] inv);
    route_sel  = sel;
    invert     = inv;
    cfg_update = 1'b1;
    tick();
    cfg_update = 1'b0;
    route_sel  = 6'b10_01_00;
    invert     = 3'b000;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    vid_pData_in = 24'h332211; vid_pVDE_in = 1'b1;
    vid_pHSync_in = 1'b1; vid_pVSync_in = 1'b0;
    route_sel = 6'b10_01_00; invert = 3'b000; cfg_update = 1'b0;
    tick(); tick();
    n_cmp++;
    if (vid_pData_out !== 24'h0) begin n_err++; $display("FAIL reset_data: got %h expected 000000", vid_pData_out); end
    n_cmp++;
    if ({vid_pVDE_out, vid_pHSync_out, vid_pVSync_out} !== 3'b000) begin
      n_err++; $display("FAIL reset_syncs: got %b expected 000", {vid_pVDE_out, vid_pHSync_out, vid_pVSync_out});
    end
    n_cmp++;
    if (cfg_pending !== 1'b0) begin n_err++; $display("FAIL reset_pending: got %b expected 0", cfg_pending); end
    #2 rst_n = 1'b1;
    vid_pHSync_in = 1'b0;
    tick();
  endtask

  task automatic test_identity();
    logic [2:0] pat [9];  // {vsync, hsync, vde}
    logic [23:0] exp_d;
    pat = '{3'b001, 3'b001, 3'b001, 3'b011, 3'b000, 3'b101, 3'b111, 3'b001, 3'b001};
    vid_pData_in = 24'h332211;
    for (int c = 0; c < 9; c++) begin
      {vid_pVSync_in, vid_pHSync_in, vid_pVDE_in} = pat[c];
      tick();
      if (c >= 1) begin
        exp_d = pat[c-1][0] ? 24'h332211 : 24'h0;
        n_cmp++;
        if (vid_pData_out !== exp_d) begin
          n_err++; $display("FAIL identity_data[%0d]: got %h expected %h", c, vid_pData_out, exp_d);
        end
        n_cmp++;
        if ({vid_pVSync_out, vid_pHSync_out, vid_pVDE_out} !== pat[c-1]) begin
          n_err++; $display("FAIL identity_syncs[%0d]: got %b expected %b", c,
                            {vid_pVSync_out, vid_pHSync_out, vid_pVDE_out}, pat[c-1]);
        end
      end
    end
    vid_pVSync_in = 1'b0; vid_pHSync_in = 1'b0; vid_pVDE_in = 1'b1;
    tick();
  endtask

  task automatic test_deferred_commit();
    strobe_cfg(6'b00_10_01, 3'b000);
    n_cmp++;
    if (cfg_pending !== 1'b1) begin n_err++; $display("FAIL deferred_pending_set: got %b expected 1", cfg_pending); end
    tick(); tick();
    n_cmp++;
    if (vid_pData_out !== 24'h332211) begin n_err++; $display("FAIL deferred_before_edge: got %h expected 332211", vid_pData_out); end
    vid_pVSync_in = 1'b1;
    tick();
    n_cmp++;
    if (vid_pData_out !== 24'h332211) begin n_err++; $display("FAIL deferred_pre_edge_pixel: got %h expected 332211", vid_pData_out); end
    n_cmp++;
    if (cfg_pending !== 1'b0) begin n_err++; $display("FAIL deferred_pending_clear: got %b expected 0", cfg_pending); end
    vid_pVSync_in = 1'b0;
    tick();
    n_cmp++;
    if (vid_pData_out !== 24'h113322) begin n_err++; $display("FAIL deferred_edge_pixel: got %h expected 113322", vid_pData_out); end
    n_cmp++;
    if (vid_pVSync_out !== 1'b1) begin n_err++; $display("FAIL deferred_vsync_out: got %b expected 1", vid_pVSync_out); end
    tick();
    n_cmp++;
    if (vid_pData_out !== 24'h113322) begin n_err++; $display("FAIL deferred_after_edge: got %h expected 113322", vid_pData_out); end
  endtask

  task automatic test_zero_invert();
    strobe_cfg(6'b11_01_00, 3'b110);
    vid_pVSync_in = 1'b1; tick();
    vid_pVSync_in = 1'b0; tick();
    tick();
    n_cmp++;
    if (vid_pData_out !== 24'hFFDD11) begin n_err++; $display("FAIL zero_invert_data: got %h expected ffdd11", vid_pData_out); end
    vid_pVDE_in = 1'b0;
    tick();
    n_cmp++;
    if (vid_pData_out !== 24'hFFDD11) begin n_err++; $display("FAIL blank_one_cycle: got %h expected ffdd11", vid_pData_out); end
    tick();
    n_cmp++;
    if (vid_pData_out !== 24'h000000) begin n_err++; $display("FAIL blank_data: got %h expected 000000", vid_pData_out); end
    n_cmp++;
    if (vid_pVDE_out !== 1'b0) begin n_err++; $display("FAIL blank_vde: got %b expected 0", vid_pVDE_out); end
    vid_pVDE_in = 1'b1;
    tick(); tick();
  endtask

  task automatic test_simultaneous();
    strobe_cfg(6'b01_00_10, 3'b000);
    n_cmp++;
    if (cfg_pending !== 1'b1) begin n_err++; $display("FAIL simul_old_pending: got %b expected 1", cfg_pending); end
    vid_pVSync_in = 1'b1;
    route_sel = 6'b00_10_01; invert = 3'b000; cfg_update = 1'b1;
    tick();
    cfg_update = 1'b0; route_sel = 6'b10_01_00;
    n_cmp++;
    if (cfg_pending !== 1'b0) begin n_err++; $display("FAIL simul_pending: got %b expected 0", cfg_pending); end
    n_cmp++;
    if (vid_pData_out !== 24'hFFDD11) begin n_err++; $display("FAIL simul_pre_edge_pixel: got %h expected ffdd11", vid_pData_out); end
    vid_pVSync_in = 1'b0;
    tick();
    n_cmp++;
    if (vid_pData_out !== 24'h113322) begin n_err++; $display("FAIL simul_edge_pixel: got %h expected 113322", vid_pData_out); end
    tick();
  endtask

  task automatic test_last_write_level();
    strobe_cfg(6'b00_00_00, 3'b000);
    tick();
    strobe_cfg(6'b01_00_10, 3'b000);
    vid_pVSync_in = 1'b1;
    tick(); tick();
    strobe_cfg(6'b00_00_10, 3'b000);
    n_cmp++;
    if (cfg_pending !== 1'b1) begin n_err++; $display("FAIL level_third_pending: got %b expected 1", cfg_pending); end
    tick(); tick();
    n_cmp++;
    if (vid_pData_out !== 24'h221133) begin n_err++; $display("FAIL level_second_committed: got %h expected 221133", vid_pData_out); end
    vid_pVSync_in = 1'b0;
    tick(); tick();
    n_cmp++;
    if (vid_pData_out !== 24'h221133) begin n_err++; $display("FAIL level_no_recommit: got %h expected 221133", vid_pData_out); end
    n_cmp++;
    if (cfg_pending !== 1'b1) begin n_err++; $display("FAIL level_still_pending: got %b expected 1", cfg_pending); end
    vid_pVSync_in = 1'b1;
    tick();
    vid_pVSync_in = 1'b0;
    tick();
    n_cmp++;
    if (vid_pData_out !== 24'h111133) begin n_err++; $display("FAIL level_third_committed: got %h expected 111133", vid_pData_out); end
    n_cmp++;
    if (cfg_pending !== 1'b0) begin n_err++; $display("FAIL level_pending_clear: got %b expected 0", cfg_pending); end
    tick();
  endtask

  task automatic test_reset_mid();
    strobe_cfg(6'b00_10_01, 3'b001);
    n_cmp++;
    if (cfg_pending !== 1'b1) begin n_err++; $display("FAIL mid_pending_before: got %b expected 1", cfg_pending); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (vid_pData_out !== 24'h0 || vid_pVDE_out !== 1'b0) begin
      n_err++; $display("FAIL mid_reset_outputs: got %h/%b expected 000000/0", vid_pData_out, vid_pVDE_out);
    end
    n_cmp++;
    if (cfg_pending !== 1'b0) begin n_err++; $display("FAIL mid_reset_pending: got %b expected 0", cfg_pending); end
    tick();
    #2 rst_n = 1'b1;
    tick();
    n_cmp++;
    if (vid_pVDE_out !== 1'b0 || vid_pData_out !== 24'h0) begin
      n_err++; $display("FAIL mid_one_after_release: got %h/%b expected 000000/0", vid_pData_out, vid_pVDE_out);
    end
    tick();
    n_cmp++;
    if (vid_pData_out !== 24'h332211) begin n_err++; $display("FAIL mid_identity: got %h expected 332211", vid_pData_out); end
    vid_pVSync_in = 1'b1; tick();
    vid_pVSync_in = 1'b0; tick(); tick();
    n_cmp++;
    if (vid_pData_out !== 24'h332211) begin n_err++; $display("FAIL mid_pending_discarded: got %h expected 332211", vid_pData_out); end
    n_cmp++;
    if (cfg_pending !== 1'b0) begin n_err++; $display("FAIL mid_pending_after: got %b expected 0", cfg_pending); end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_deferred_commit();
    test_zero_invert();
    test_simultaneous();
    test_last_write_level();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
